// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the data memory controller.
// The master side drives requests; the slave side returns status and load data.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic        ready;
    logic        busy;
    logic        rvalid;
    logic [31:0] data_r;
    logic        err;

    modport master (
        output req, we, funct3, addr, data_w,
        input  ready, busy, rvalid, data_r, err
    );

    modport slave (
        input  req, we, funct3, addr, data_w,
        output ready, busy, rvalid, data_r, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with post-reset clear, sized loads/stores and a registered read port.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dmem_ctrl #(
    parameter int unsigned DEPTH = 1024
) (
    input logic        clk_i,
    input logic        rst_i,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {StClear, StIdle} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          clr_we;
    logic          accept;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          is_b, is_h, is_w, legal, misal, fault;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [15:0]   lane;
    logic [31:0]   ld_data;

    logic          rvalid_q, err_q;
    logic [31:0]   data_r_q;

    logic          unused_addr;
    assign unused_addr = ^bus.addr[31:AW+2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            StClear: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle:  state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.busy  = (state_q == StClear);
    assign accept    = bus.req && (state_q == StIdle);

    always_comb begin
        idx   = bus.addr[AW+1:2];
        off   = bus.addr[1:0];
        is_b  = 1'b0;
        is_h  = 1'b0;
        is_w  = 1'b0;
        legal = 1'b1;
        case (bus.funct3)
            3'b000, 3'b100: is_b = 1'b1;
            3'b001, 3'b101: is_h = 1'b1;
            3'b010:         is_w = 1'b1;
            default:        legal = 1'b0;
        endcase
        misal = (is_h && off[0]) || (is_w && (off != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
        fault = !legal || misal;
`else
        fault = !legal;
        if (misal) begin
            off = is_h ? {off[1], 1'b0} : 2'b00;
        end
`endif
        be = 4'b0000;
        if (is_b) begin
            be = 4'b0001 << off;
        end else if (is_h) begin
            be = off[1] ? 4'b1100 : 4'b0011;
        end else if (is_w) begin
            be = 4'b1111;
        end
        if (fault) begin
            be = 4'b0000;
        end
        // Replicate narrow data across lanes so the byte enables pick the right copy.
        if (is_b) begin
            wdata = {4{bus.data_w[7:0]}};
        end else if (is_h) begin
            wdata = {2{bus.data_w[15:0]}};
        end else begin
            wdata = bus.data_w;
        end

        rword = mem[idx];
        lane  = 16'(rword >> {off, 3'b000});
        case (bus.funct3)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane};
            3'b101:  ld_data = {16'd0, lane};
            3'b010:  ld_data = rword;
            default: ld_data = '0;
        endcase
        if (fault) begin
            ld_data = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else if (accept && bus.we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            data_r_q <= '0;
        end else begin
            rvalid_q <= accept && !bus.we;
            err_q    <= accept && fault;
            if (accept && !bus.we) begin
                data_r_q <= ld_data;
            end
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.data_r = data_r_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random traffic against a behavioural model.
module tb_dmem_ctrl;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: a word array plus a count of remaining clear cycles.
    logic [31:0] m_mem [DEPTH];
    int          clr_left = DEPTH;
    bit          started  = 1'b0;
    logic        e_rvalid = 1'b0;
    logic        e_err    = 1'b0;
    logic [31:0] e_data   = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    task automatic model_access();
        int unsigned w;
        int unsigned o;
        int unsigned sz;
        bit          uns;
        bit          bad;
        bit          mis;
        logic [31:0] v;
        w   = (bus.addr >> 2) % DEPTH;
        o   = bus.addr & 32'd3;
        uns = 1'b0;
        case (bus.funct3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin sz = 1; uns = 1'b1; end
            3'd5: begin sz = 2; uns = 1'b1; end
            default: sz = 0;
        endcase
        bad = (sz == 0);
        mis = (sz > 1) && ((o % sz) != 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        bad = bad || mis;
`else
        if (mis) o = o - (o % sz);
`endif
        e_err = bad;
        if (bus.we) begin
            if (!bad) begin
                for (int k = 0; k < int'(sz); k++) begin
                    m_mem[w][8*(int'(o)+k) +: 8] = bus.data_w[8*k +: 8];
                end
            end
        end else begin
            e_rvalid = 1'b1;
            if (bad) begin
                e_data = '0;
            end else begin
                v = m_mem[w] >> (8 * o);
                if (sz == 1)      e_data = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                else if (sz == 2) e_data = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else              e_data = m_mem[w];
            end
        end
    endtask

    always @(posedge clk) begin
        e_rvalid = 1'b0;
        e_err    = 1'b0;
        if (rst) begin
            clr_left = DEPTH;
            e_data   = '0;
            started  = 1'b1;
        end else if (clr_left > 0) begin
            m_mem[DEPTH - clr_left] = '0;
            clr_left--;
        end else if (bus.req) begin
            model_access();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready",  {31'd0, bus.ready},  {31'd0, clr_left == 0});
            check("busy",   {31'd0, bus.busy},   {31'd0, clr_left != 0});
            check("rvalid", {31'd0, bus.rvalid}, {31'd0, e_rvalid});
            check("err",    {31'd0, bus.err},    {31'd0, e_err});
            check("data_r", bus.data_r, e_data);
        end
    end

    task automatic drive(input logic we_, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        bus.req    = 1'b1;
        bus.we     = we_;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.data_w = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] want);
        drive(1'b0, f3, a, 32'd0);
        @(negedge clk);
        check({name, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
        check(name, bus.data_r, want);
    endtask

    task automatic do_reset_and_clear(input string name);
        int n;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (bus.busy && n < int'(DEPTH) + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, DEPTH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'd0;
        bus.addr   = '0;
        bus.data_w = '0;

        do_reset_and_clear("clear_len");
        load_chk("lw_0x0",   3'b010, 32'h0,   32'h0);
        load_chk("lw_0x400", 3'b010, 32'h400, 32'h0);
        load_chk("lw_0xffc", 3'b010, 32'hFFC, 32'h0);

        drive(1'b1, 3'b010, 32'h10, 32'h1122_3344);
        drive(1'b1, 3'b000, 32'h11, 32'h0000_00AA);
        drive(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        check("merge_lw", bus.data_r, 32'h1122_AA44);

        drive(1'b1, 3'b010, 32'h20, 32'h80F0_7F81);
        load_chk("lb",  3'b000, 32'h20, 32'hFFFF_FF81);
        load_chk("lbu", 3'b100, 32'h20, 32'h0000_0081);
        load_chk("lh",  3'b001, 32'h22, 32'hFFFF_80F0);
        load_chk("lhu", 3'b101, 32'h22, 32'h0000_80F0);

        drive(1'b1, 3'b010, 32'h4, 32'hCAFE_F00D);
        drive(1'b0, 3'b010, 32'h6, 32'h0);
        @(negedge clk);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_mis_err",  {31'd0, bus.err}, 32'd1);
        check("lw_mis_data", bus.data_r, 32'h0);
        drive(1'b1, 3'b001, 32'h3, 32'h0000_BEEF);
        @(negedge clk);
        check("sh_mis_err", {31'd0, bus.err}, 32'd1);
        load_chk("sh_mis_unchanged", 3'b010, 32'h0, 32'h0);
`else
        check("lw_mis_err",  {31'd0, bus.err}, 32'd0);
        check("lw_mis_data", bus.data_r, 32'hCAFE_F00D);
`endif

        drive(1'b1, 3'b010, 32'h30, 32'h5555_AAAA);
        drive(1'b1, 3'b011, 32'h30, 32'h1234_5678);
        @(negedge clk);
        check("f3_011_err", {31'd0, bus.err}, 32'd1);
        load_chk("f3_011_unchanged", 3'b010, 32'h30, 32'h5555_AAAA);
        drive(1'b1, 3'b010, 32'h1000, 32'hA5A5_0001);
        load_chk("alias_word0", 3'b010, 32'h0, 32'hA5A5_0001);

        // Random traffic, concentrated on a small window to force read-after-write hits.
        for (int i = 0; i < 3000; i++) begin
            r          = $urandom;
            bus.req    = ($urandom_range(0, 3) != 0);
            bus.we     = $urandom_range(0, 1) == 1;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.addr   = ($urandom_range(0, 7) == 0) ? r : (r & 32'h0000_00FF);
            bus.data_w = $urandom;
            @(posedge clk);
            #1;
        end
        bus.req = 1'b0;

        drive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        do_reset_and_clear("clear_restart_len");
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 3'b010, 32'(i * 4), 32'h0);
        end
        load_chk("after_restart_0x10", 3'b010, 32'h10, 32'h0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
